// File: rtl/star_scanner_if.sv
// Star scanner bus: frame-buffer read port, star report handshake and scan status.
// master = scanner side, slave = frame buffer / measurement block side.
interface star_scanner_if #(
  parameter int unsigned X_SZ    = 8,
  parameter int unsigned Y_SZ    = 7,
  parameter int unsigned COL_SZ  = 3,
  parameter int unsigned ADDR_SZ = 15
);
  logic               start;
  logic [ADDR_SZ-1:0] memAddr;
  logic [COL_SZ-1:0]  pixVal;
  logic               starFound;
  logic [X_SZ-1:0]    xOut;
  logic [Y_SZ-1:0]    yOut;
  logic               measureDone;
  logic               scanDone;
  logic [7:0]         starCount;

  modport master (
    input  start, pixVal, measureDone,
    output memAddr, starFound, xOut, yOut, scanDone, starCount
  );

  modport slave (
    output start, pixVal, measureDone,
    input  memAddr, starFound, xOut, yOut, scanDone, starCount
  );
endinterface

// File: rtl/star_scanner.sv
// Frame scanner: walks every pixel of a frame buffer in raster order, reports each
// bright pixel to a downstream measurement block and waits for its release.
// Optional macro STAR_EDGE_EN: report only dark-to-bright transitions within a row.
module star_scanner #(
  parameter int unsigned X_SZ      = 8,
  parameter int unsigned Y_SZ      = 7,
  parameter int unsigned X_RES     = 160,
  parameter int unsigned Y_RES     = 120,
  parameter int unsigned COL_SZ    = 3,
  parameter int unsigned ADDR_SZ   = 15,
  parameter int unsigned THRESHOLD = 0
) (
  input logic               clk,
  input logic               resetn,
  star_scanner_if.master    bus
);

  // The advance step is folded into the CHECK / WAIT_ACK exits, so it has no state.
  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StCheck,
    StFound,
    StWaitAck,
    StDone
  } state_e;

  localparam logic [X_SZ-1:0]    XLast  = X_SZ'(X_RES - 1);
  localparam logic [Y_SZ-1:0]    YLast  = Y_SZ'(Y_RES - 1);
  localparam logic [ADDR_SZ-1:0] XResA  = ADDR_SZ'(X_RES);
  localparam logic [COL_SZ-1:0]  Thresh = COL_SZ'(THRESHOLD);

  state_e          state_q, state_d;
  logic [X_SZ-1:0] x_q, x_d;
  logic [Y_SZ-1:0] y_q, y_d;
  logic [X_SZ-1:0] x_out_q, x_out_d;
  logic [Y_SZ-1:0] y_out_q, y_out_d;
  logic [7:0]      count_q, count_d;
  logic            bright;
  logic            qualified;
  logic            advance;
  logic            last_col;
  logic            last_row;
`ifdef STAR_EDGE_EN
  logic            prev_q, prev_d;
`endif

  assign bright   = bus.pixVal > Thresh;
  assign last_col = (x_q == XLast);
  assign last_row = (y_q == YLast);

`ifdef STAR_EDGE_EN
  // Column 0 always counts as preceded by a dark pixel.
  assign qualified = bright && ((x_q == '0) || !prev_q);
`else
  assign qualified = bright;
`endif

  // State and counter registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      x_out_q <= '0;
      y_out_q <= '0;
      count_q <= '0;
`ifdef STAR_EDGE_EN
      prev_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      x_out_q <= x_out_d;
      y_out_q <= y_out_d;
      count_q <= count_d;
`ifdef STAR_EDGE_EN
      prev_q  <= prev_d;
`endif
    end
  end

  // Next-state logic, including the raster advance on CHECK / WAIT_ACK exit.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    x_out_d = x_out_q;
    y_out_d = y_out_q;
    count_d = count_q;
    advance = 1'b0;
`ifdef STAR_EDGE_EN
    prev_d  = prev_q;
`endif

    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          state_d = StFetch;
          x_d     = '0;
          y_d     = '0;
          count_d = '0;
`ifdef STAR_EDGE_EN
          prev_d  = 1'b0;
`endif
        end
      end
      StFetch: state_d = StCheck;
      StCheck: begin
`ifdef STAR_EDGE_EN
        prev_d = bright;
`endif
        if (qualified) begin
          // Coordinates and count are captured on entry so they are valid with the pulse.
          state_d = StFound;
          x_out_d = x_q;
          y_out_d = y_q;
          if (count_q != 8'hff) count_d = count_q + 8'd1;
        end else begin
          advance = 1'b1;
        end
      end
      StFound:   state_d = StWaitAck;
      StWaitAck: if (bus.measureDone) advance = 1'b1;
      default:   state_d = StIdle;
    endcase

    if (advance) begin
      if (last_col) begin
        if (last_row) begin
          // Counters stay on the last pixel: no read of address 0 after the frame.
          state_d = StDone;
        end else begin
          state_d = StFetch;
          x_d     = '0;
          y_d     = y_q + Y_SZ'(1);
`ifdef STAR_EDGE_EN
          prev_d  = 1'b0;
`endif
        end
      end else begin
        state_d = StFetch;
        x_d     = x_q + X_SZ'(1);
      end
    end
  end

  // Outputs; the multiply by a constant X_RES reduces to shift-adds.
  always_comb begin
    bus.memAddr   = ADDR_SZ'(y_q) * XResA + ADDR_SZ'(x_q);
    bus.starFound = (state_q == StFound);
    bus.scanDone  = (state_q == StDone);
    bus.xOut      = x_out_q;
    bus.yOut      = y_out_q;
    bus.starCount = count_q;
  end

endmodule

// File: tb/tb_star_scanner.sv
// Self-checking bench for star_scanner: frame-buffer RAM model, scoreboard of
// expected star reports and a responder that acknowledges each report.
module tb_star_scanner;

  localparam int XRES = 160;
  localparam int YRES = 120;
  localparam int NPIX = XRES * YRES;

  typedef struct {
    int x;
    int y;
    int delay;
    bit no_ack;
  } exp_t;

  typedef struct {
    int x;
    int y;
    int pix;
    bit rep_edge;
    bit rep_plain;
    int delay;
  } vec_t;

  logic clk = 1'b0;
  logic resetn;
  logic [2:0] mem [0:NPIX-1];
  exp_t sbq[$];
  int n_checks = 0;
  int n_pass = 0;
  int n_rep = 0;
  bit mon_en = 1'b0;

  star_scanner_if #(.X_SZ(8), .Y_SZ(7), .COL_SZ(3), .ADDR_SZ(15)) bus ();

  star_scanner #(
    .X_SZ(8), .Y_SZ(7), .X_RES(XRES), .Y_RES(YRES), .COL_SZ(3), .ADDR_SZ(15), .THRESHOLD(0)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Synchronous frame-buffer RAM: data one cycle after the address.
  always_ff @(posedge clk) begin
    if (int'(bus.memAddr) < NPIX) bus.pixVal <= mem[bus.memAddr];
    else bus.pixVal <= '0;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Responder: pops the scoreboard on each report and releases the scanner.
  initial begin : responder
    exp_t e;
    int addr;
    forever begin
      @(negedge clk);
      if (mon_en && bus.starFound) begin
        n_rep++;
        check("report_expected", int'(sbq.size() > 0), 1);
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          check("x_out", int'(bus.xOut), e.x);
          check("y_out", int'(bus.yOut), e.y);
          check("star_count", int'(bus.starCount), (n_rep > 255) ? 255 : n_rep);
          if (!e.no_ack) begin
            repeat (e.delay) @(negedge clk);
            check("pulse_single", int'(bus.starFound), 0);
            check("x_out_held", int'(bus.xOut), e.x);
            bus.measureDone = 1'b1;
            @(negedge clk);
            bus.measureDone = 1'b0;
            addr = e.y * XRES + e.x;
            if (addr == NPIX - 1) begin
              check("last_done", int'(bus.scanDone), 1);
              check("last_no_wrap", int'(bus.memAddr), NPIX - 1);
            end else begin
              check("resume_addr", int'(bus.memAddr), addr + 1);
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #950000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation time limit");
  end

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  initial begin : main
    vec_t tbl[8];
    exp_t e;
    int i;
    int found;
    int k;
    bit gen_done;

    tbl = '{
      '{x: 10,  y: 0,   pix: 3, rep_edge: 1'b1, rep_plain: 1'b1, delay: 1},
      '{x: 11,  y: 0,   pix: 7, rep_edge: 1'b0, rep_plain: 1'b1, delay: 2},
      '{x: 12,  y: 0,   pix: 1, rep_edge: 1'b0, rep_plain: 1'b1, delay: 1},
      '{x: 158, y: 1,   pix: 5, rep_edge: 1'b1, rep_plain: 1'b1, delay: 1},
      '{x: 159, y: 1,   pix: 6, rep_edge: 1'b0, rep_plain: 1'b1, delay: 1},
      '{x: 0,   y: 2,   pix: 6, rep_edge: 1'b1, rep_plain: 1'b1, delay: 3},
      '{x: 5,   y: 3,   pix: 2, rep_edge: 1'b1, rep_plain: 1'b1, delay: 4},
      '{x: 159, y: 119, pix: 4, rep_edge: 1'b1, rep_plain: 1'b1, delay: 1}
    };

    bus.start = 1'b0;
    bus.measureDone = 1'b0;
    resetn = 1'b0;
    for (int a = 0; a < NPIX; a++) mem[a] = '0;
    repeat (3) @(negedge clk);
    check("rst_scan_done", int'(bus.scanDone), 0);
    check("rst_star_found", int'(bus.starFound), 0);
    check("rst_star_count", int'(bus.starCount), 0);
    check("rst_mem_addr", int'(bus.memAddr), 0);
    check("rst_x_out", int'(bus.xOut), 0);
    check("rst_y_out", int'(bus.yOut), 0);
    resetn = 1'b1;
    mon_en = 1'b1;

    // Reset while waiting for acknowledge at (20,7).
    mem[7 * XRES + 20] = 3'd5;
    e = '{x: 20, y: 7, delay: 0, no_ack: 1'b1};
    sbq.push_back(e);
    pulse_start();
    for (i = 0; i < 5000 && !bus.starFound; i++) @(negedge clk);
    check("a_found_in_time", int'(i < 5000), 1);
    repeat (2) @(negedge clk);
    check("a_wait_count", int'(bus.starCount), 1);
    check("a_wait_no_pulse", int'(bus.starFound), 0);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    check("a_rst_x_out", int'(bus.xOut), 0);
    check("a_rst_y_out", int'(bus.yOut), 0);
    check("a_rst_count", int'(bus.starCount), 0);
    check("a_rst_addr", int'(bus.memAddr), 0);
    @(negedge clk);
    bus.measureDone = 1'b1;
    @(negedge clk);
    bus.measureDone = 1'b0;
    repeat (3) @(negedge clk);
    check("a_idle_addr", int'(bus.memAddr), 0);
    check("a_idle_count", int'(bus.starCount), 0);
    check("a_idle_done", int'(bus.scanDone), 0);
    check("a_sb_empty", sbq.size(), 0);
    mem[7 * XRES + 20] = '0;

    // All-dark frame: start launched after edge k, done visible after edge k+38401.
    found = 0;
    n_rep = 0;
    @(negedge clk);
    bus.start = 1'b1;
    for (int c = 1; c <= 2 * NPIX + 1; c++) begin
      @(negedge clk);
      if (c == 1) bus.start = 1'b0;
      if (bus.starFound) found++;
      if (c == 2 * NPIX) check("b_done_early", int'(bus.scanDone), 0);
      if (c == 2 * NPIX + 1) check("b_done_on_time", int'(bus.scanDone), 1);
    end
    check("b_no_reports", found, 0);
    check("b_count_zero", int'(bus.starCount), 0);

    // Frame with table features plus 300 isolated bright pixels for saturation.
    n_rep = 0;
    gen_done = 1'b0;
    for (int t = 0; t < 8; t++) begin
      if (tbl[t].y >= 60 && !gen_done) begin
        gen_done = 1'b1;
        k = 0;
        for (int r = 60; r < 64 && k < 300; r++) begin
          for (int xx = 0; xx < XRES && k < 300; xx += 2) begin
            mem[r * XRES + xx] = 3'((k % 7) + 1);
            e = '{x: xx, y: r, delay: 1, no_ack: 1'b0};
            sbq.push_back(e);
            k++;
          end
        end
      end
      mem[tbl[t].y * XRES + tbl[t].x] = 3'(tbl[t].pix);
`ifdef STAR_EDGE_EN
      if (tbl[t].rep_edge) begin
`else
      if (tbl[t].rep_plain) begin
`endif
        e = '{x: tbl[t].x, y: tbl[t].y, delay: tbl[t].delay, no_ack: 1'b0};
        sbq.push_back(e);
      end
    end
    pulse_start();
    check("c_done_dropped", int'(bus.scanDone), 0);
    for (i = 0; i < 45000 && !bus.scanDone; i++) begin
      @(negedge clk);
      // Stray start and measureDone mid-scan must be ignored.
      if (i == 400) bus.start = 1'b1;
      if (i == 401) bus.start = 1'b0;
      if (i == 1700) bus.measureDone = 1'b1;
      if (i == 1701) bus.measureDone = 1'b0;
    end
    check("c_done_in_time", int'(bus.scanDone), 1);
    check("c_count_sat", int'(bus.starCount), 255);
    check("c_sb_empty", sbq.size(), 0);
    check("c_final_addr", int'(bus.memAddr), NPIX - 1);
    repeat (2) @(negedge clk);

    // Start and measureDone together in DONE: restart wins.
    bus.start = 1'b1;
    bus.measureDone = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.measureDone = 1'b0;
    check("d_done_cleared", int'(bus.scanDone), 0);
    check("d_addr_zero", int'(bus.memAddr), 0);
    check("d_count_zero", int'(bus.starCount), 0);
    repeat (2) @(negedge clk);
    check("d_addr_next", int'(bus.memAddr), 1);
    mon_en = 1'b0;
    resetn = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
